// File: rtl/prng_pkg.sv
// Shared types and constants for the Lehmer PRNG scheduler.
// Holds the FSM state encoding, the core operand defaults and the seed reset values.
package prng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    START,
    WAIT,
    RESP
  } state_e;

  localparam logic [31:0] DEF_M = 32'h7FFF_FFFF;
  localparam logic [31:0] DEF_A = 32'd16807;

  // Reset seed for channel k: 5, 7, 9, 11, ... keeps every channel odd and distinct.
  function automatic logic [31:0] def_seed(input int unsigned k);
    return 32'(2 * k + 5);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requesting channel at or after ptr.
// The pointer itself is owned and advanced by the caller.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             any
);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
    any = found;
  end

endmodule

// File: rtl/prng_sched.sv
// Round-robin scheduler sharing one Lehmer PRNG core among N_REQ channels,
// each channel keeping its own seed that is replaced by every result it receives.
module prng_sched #(
  parameter int          N_REQ   = 4,
  parameter logic [31:0] DEF_M   = prng_pkg::DEF_M,
  parameter logic [31:0] DEF_A   = prng_pkg::DEF_A,
  parameter int          TIMEOUT = 1023,
  localparam int         IDW     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  input  logic             cfg_we,
  input  logic [IDW-1:0]   cfg_idx,
  input  logic [31:0]      cfg_seed,
  output logic             prng_start,
  output logic [31:0]      prng_seed,
  output logic [31:0]      prng_m,
  output logic [31:0]      prng_a,
  input  logic             prng_done,
  input  logic [31:0]      prng_rand,
  output logic             rsp_valid,
  output logic [IDW-1:0]   rsp_id,
  output logic [31:0]      rsp_data,
  input  logic             rsp_ready,
  output logic             busy,
  output logic             err_timeout
);

  import prng_pkg::*;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic [IDW-1:0]          cur_id_q, cur_id_d;
  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [31:0]             seed_q, seed_d;
  logic [31:0]             rsp_data_q, rsp_data_d;
  logic [CW-1:0]           wcnt_q, wcnt_d;
  logic                    err_q, err_d;
  logic [N_REQ-1:0][31:0]  bank_q, bank_d;

  logic [N_REQ-1:0]        arb_gnt;
  logic [IDW-1:0]          arb_id;
  logic                    arb_any;

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .gnt    (arb_gnt),
    .gnt_id (arb_id),
    .any    (arb_any)
  );

  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    ptr_d      = ptr_q;
    seed_d     = seed_q;
    rsp_data_d = rsp_data_q;
    wcnt_d     = wcnt_q;
    err_d      = err_q;
    bank_d     = bank_q;

    case (state_q)
      IDLE: if (|req) state_d = ARB;
      ARB: begin
        // A request withdrawn before its grant is simply dropped.
        if (arb_any) begin
          cur_id_d = arb_id;
          seed_d   = bank_q[arb_id];
          state_d  = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q + CW'(1);
        // The first WAIT cycle ignores done: it may be a stale level from the last run.
        if (prng_done && wcnt_q != '0) begin
          rsp_data_d       = prng_rand;
          bank_d[cur_id_q] = prng_rand;
          state_d          = RESP;
        end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          ptr_d   = (cur_id_q == IDW'(N_REQ - 1)) ? '0 : cur_id_q + IDW'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Placed after the writeback so a config write to the same channel wins.
    if (cfg_we && int'(cfg_idx) < N_REQ) bank_d[cfg_idx] = cfg_seed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_id_q   <= '0;
      ptr_q      <= '0;
      seed_q     <= '0;
      rsp_data_q <= '0;
      wcnt_q     <= '0;
      err_q      <= 1'b0;
      for (int k = 0; k < N_REQ; k++) bank_q[k] <= def_seed(k);
    end else begin
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      ptr_q      <= ptr_d;
      seed_q     <= seed_d;
      rsp_data_q <= rsp_data_d;
      wcnt_q     <= wcnt_d;
      err_q      <= err_d;
      bank_q     <= bank_d;
    end
  end

  assign gnt         = (state_q == ARB) ? arb_gnt : '0;
  assign prng_start  = (state_q == START);
  assign prng_seed   = seed_q;
  assign prng_m      = DEF_M;
  assign prng_a      = DEF_A;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = cur_id_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_prng_sched.sv
// Bench for prng_sched: minstd core model, per-channel seed model and a response scoreboard.
module tb_prng_sched;

  localparam int          N = 4;
  localparam logic [31:0] M = 32'h7FFF_FFFF;
  localparam logic [31:0] A = 32'd16807;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic          cfg_we;
  logic [1:0]    cfg_idx;
  logic [31:0]   cfg_seed;
  logic          prng_start;
  logic [31:0]   prng_seed, prng_m, prng_a;
  logic          prng_done;
  logic [31:0]   prng_rand;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_data;
  logic          rsp_ready;
  logic          busy;
  logic          err_timeout;

  int checks   = 0;
  int failures = 0;

  prng_sched #(.N_REQ(N), .TIMEOUT(1023)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_seed(cfg_seed),
    .prng_start(prng_start), .prng_seed(prng_seed), .prng_m(prng_m), .prng_a(prng_a),
    .prng_done(prng_done), .prng_rand(prng_rand),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lehmer(input logic [31:0] s);
    logic [63:0] p;
    p = 64'(s) * 64'(A);
    return 32'(p % 64'(M));
  endfunction

  // Core model: done pulses 4 cycles after start unless hung.
  logic        core_hang;
  int          core_cnt;
  logic [31:0] core_seed;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_cnt  <= 0;
      prng_done <= 1'b0;
      prng_rand <= '0;
      core_seed <= '0;
    end else begin
      prng_done <= 1'b0;
      if (prng_start) begin
        core_seed <= prng_seed;
        core_cnt  <= 3;
      end else if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1 && !core_hang) begin
          prng_done <= 1'b1;
          prng_rand <= lehmer(core_seed);
        end
      end
    end
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mseed [N];

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got id=%0d data=%0d, required no response", rsp_id, rsp_data);
      end else begin
        mon_e = sb.pop_front();
        if ({rsp_id, rsp_data} !== mon_e) begin
          failures++;
          $display("FAIL rsp_data: got id=%0d data=%0d, required id=%0d data=%0d",
                   rsp_id, rsp_data, mon_e.id, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int ch);
    mseed[ch] = lehmer(mseed[ch]);
    sb.push_back({2'(ch), mseed[ch]});
  endtask

  task automatic model_reset();
    sb.delete();
    for (int k = 0; k < N; k++) mseed[k] = 32'(2 * k + 5);
  endtask

  task automatic apply_reset();
    #1;
    rst_n = 1'b0; req = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_seed = '0;
    rsp_ready = 1'b1; core_hang = 1'b0;
    model_reset();
    #12;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_gnt(output logic [N-1:0] g);
    g = '0;
    for (int i = 0; i < 2000 && g == '0; i++) begin
      tick();
      g = gnt;
    end
    if (g == '0) begin
      checks++; failures++;
      $display("FAIL gnt_timeout: got no grant, required a grant within 2000 cycles");
    end
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 3000; i++) begin
      if (sb.size() == 0 && !busy) break;
      tick();
    end
    checks++;
    if (i == 3000) begin
      failures++;
      $display("FAIL drain_timeout: pending=%0d busy=%0b, required 0 pending and idle", sb.size(), busy);
    end
  endtask

  task automatic serve(input int ch);
    logic [N-1:0] g;
    req[ch] = 1'b1;
    push_exp(ch);
    wait_gnt(g);
    checks++;
    if (g !== N'(1 << ch)) begin
      failures++;
      $display("FAIL serve_gnt: got %b, required %b", g, N'(1 << ch));
    end
    tick();
    req[ch] = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; cfg_we = 1'b0; cfg_idx = '0; cfg_seed = '0;
    rsp_ready = 1'b1; core_hang = 1'b0;
    model_reset();
    #13;
    checks++;
    if ({gnt, prng_start, rsp_valid, busy, err_timeout} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: got gnt=%b start=%b valid=%b busy=%b err=%b, required all 0",
               gnt, prng_start, rsp_valid, busy, err_timeout);
    end
    checks++;
    if (prng_seed !== 0 || rsp_id !== 0 || rsp_data !== 0) begin
      failures++;
      $display("FAIL reset_data: got seed=%0d id=%0d data=%0d, required 0 0 0", prng_seed, rsp_id, rsp_data);
    end
    checks++;
    if (prng_m !== M || prng_a !== A) begin
      failures++;
      $display("FAIL reset_operands: got m=%h a=%0d, required m=%h a=%0d", prng_m, prng_a, M, A);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0001;
    push_exp(0);
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL single_gnt_latency: got %b, required 0001", gnt);
    end
    tick();
    checks++;
    if (prng_start !== 1'b1 || prng_seed !== 32'd5) begin
      failures++;
      $display("FAIL single_start: got start=%b seed=%0d, required start=1 seed=5", prng_start, prng_seed);
    end
    req = '0;
    wait_drain();
    serve(0);
  endtask

  task automatic test_contention();
    int ord[5];
    logic [N-1:0] g;
    apply_reset();
    ord = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) push_exp(ord[k]);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(g);
      checks++;
      if (g !== N'(1 << ord[k])) begin
        failures++;
        $display("FAIL contention_order[%0d]: got %b, required %b", k, g, N'(1 << ord[k]));
      end
    end
    tick();
    req = '0;
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] g;
    logic [1:0]   id0;
    logic [31:0]  d0;
    logic         stable;
    int           i;
    apply_reset();
    rsp_ready = 1'b0;
    req = 4'b0001;
    push_exp(0);
    wait_gnt(g);
    tick();
    req = 4'b0010;
    for (i = 0; i < 100 && !rsp_valid; i++) tick();
    checks++;
    if (!rsp_valid) begin
      failures++;
      $display("FAIL bp_valid: got rsp_valid=0, required 1 within 100 cycles");
    end
    id0 = rsp_id; d0 = rsp_data; stable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!rsp_valid || rsp_id !== id0 || rsp_data !== d0 || gnt !== '0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL bp_stable: got a change over 20 stalled cycles, required valid/id/data held and gnt=0");
    end
    push_exp(1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got busy=%b valid=%b, required 0 0", busy, rsp_valid);
    end
    rsp_ready = 1'b1;
    wait_gnt(g);
    checks++;
    if (g !== 4'b0010) begin
      failures++;
      $display("FAIL bp_next_gnt: got %b, required 0010", g);
    end
    tick();
    req = '0;
    wait_drain();
  endtask

  task automatic test_config();
    logic [N-1:0] g;
    int i;
    apply_reset();
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_seed = 32'd1;
    mseed[2] = 32'd1;
    tick();
    cfg_we = 1'b0;
    serve(2);
    req = 4'b0100;
    push_exp(2);
    wait_gnt(g);
    tick();
    req = '0;
    for (i = 0; i < 100 && !prng_done; i++) tick();
    checks++;
    if (!prng_done) begin
      failures++;
      $display("FAIL cfg_done_seen: got no prng_done, required one within 100 cycles");
    end
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_seed = 32'd12345;
    tick();
    cfg_we = 1'b0;
    mseed[2] = 32'd12345;
    wait_drain();
    serve(2);
  endtask

  task automatic test_timeout();
    logic [N-1:0] g;
    int n;
    apply_reset();
    core_hang = 1'b1;
    req = 4'b1000;
    sb.push_back({2'd3, 32'd0});
    wait_gnt(g);
    tick();
    req = '0;
    checks++;
    if (prng_start !== 1'b1) begin
      failures++;
      $display("FAIL to_start: got start=%b, required 1", prng_start);
    end
    n = 0;
    while (n < 1200 && !rsp_valid) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 1024) begin
      failures++;
      $display("FAIL to_latency: got %0d cycles start-to-valid, required 1024", n);
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL to_err: got err_timeout=%b, required 1", err_timeout);
    end
    wait_drain();
    core_hang = 1'b0;
    serve(3);
    checks++;
    if (err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky: got err_timeout=%b, required 1", err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] g;
    apply_reset();
    req = 4'b0001;
    wait_gnt(g);
    tick();
    req = '0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, prng_start, rsp_valid, busy, err_timeout} !== '0 || prng_seed !== 0 || rsp_data !== 0) begin
      failures++;
      $display("FAIL mid_reset: got busy=%b start=%b valid=%b seed=%0d data=%0d, required all 0",
               busy, prng_start, rsp_valid, prng_seed, rsp_data);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    serve(1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_config();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
